pkt_collector: RTL



---
 rtl/pkt_collector_pkg.sv | 25 ++
 rtl/pkt_collector_if.sv | 24 ++
 rtl/pkt_collector_fifo.sv | 60 ++++++
 rtl/pkt_collector.sv | 102 ++++++++++
 4 files changed

// File: rtl/pkt_collector_pkg.sv
// pkt_pkg: shared constants and types for the packet collector.
//   PKT_W / NUM_PORTS  packet width and number of serial lines
//   *_MSB / *_LSB      packet field positions (carried, not interpreted)
//   collect_state_t    deserializer FSM states
//   pkt_entry_t        one FIFO entry: packet word plus port mask
package pkt_pkg;

  localparam int PKT_W     = 64;
  localparam int NUM_PORTS = 4;

  localparam int DEST_MSB    = 63;
  localparam int DEST_LSB    = 48;
  localparam int SRC_MSB     = 47;
  localparam int SRC_LSB     = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic {IDLE, SHIFT} collect_state_t;

  typedef struct packed {
    logic [PKT_W-1:0]     data;
    logic [NUM_PORTS-1:0] port;
  } pkt_entry_t;

endpackage

// File: rtl/pkt_collector_if.sv
// Bus interfaces of the packet collector.
//   ser_if: serial side from the switch (ser_valid strobe, ser_data lines);
//           master = switch, slave = collector.
//   pkt_if: parallel ready/valid packet side (pkt_valid, pkt_ready,
//           pkt_data, pkt_port); master = collector, slave = consumer.
interface ser_if;
  import pkt_pkg::*;
  logic                 ser_valid;
  logic [NUM_PORTS-1:0] ser_data;

  modport master (output ser_valid, ser_data);
  modport slave  (input  ser_valid, ser_data);
endinterface

interface pkt_if;
  import pkt_pkg::*;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [PKT_W-1:0]     pkt_data;
  logic [NUM_PORTS-1:0] pkt_port;

  modport master (output pkt_valid, pkt_data, pkt_port, input  pkt_ready);
  modport slave  (input  pkt_valid, pkt_data, pkt_port, output pkt_ready);
endinterface

// File: rtl/pkt_collector_fifo.sv
// pkt_fifo: synchronous FIFO holding completed packet entries.
//   clk, rst  clock, synchronous active-high reset
//   push/din  write request and entry
//   accept    push taken this cycle (not full, or full with a pop)
//   pop       read request; ignored when empty
//   dout      head entry, forced to zero when empty
//   empty     no entries
//   level     current occupancy, 0..DEPTH
module pkt_fifo
  import pkt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  pkt_entry_t                 din,
  output logic                       accept,
  input  logic                       pop,
  output pkt_entry_t                 dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  pkt_entry_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                full, do_pop;

  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign do_pop = pop & ~empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign accept = push & (~full | do_pop);
  // Zero head when empty keeps the output bus clean after reset/drain.
  assign dout   = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pkt_collector.sv
// pkt_collector: deserializes 64-bit MSB-first packets from four one-hot
// serial lines, records which lines carried them, queues them in a FIFO
// and presents them on a ready/valid bus. Keeps packet/drop/runt stats.
//   clk, rst     clock, synchronous active-high reset
//   ser          serial input (ser_valid, ser_data[3:0])
//   pkt          packet output (pkt_valid, pkt_ready, pkt_data, pkt_port)
//   fifo_level   FIFO occupancy
//   pkt_cnt      packets written to FIFO (wraps)
//   drop_cnt     packets lost to a full FIFO (saturates)
//   runt_cnt     packets ended before 64 bits (saturates)
module pkt_collector
  import pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  ser_if.slave                        ser,
  pkt_if.master                       pkt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 pkt_cnt,
  output logic [STAT_W-1:0]           drop_cnt,
  output logic [STAT_W-1:0]           runt_cnt
);

  collect_state_t       state;
  logic [5:0]           bit_cnt;
  logic [PKT_W-2:0]     shreg;
  logic [NUM_PORTS-1:0] mask;

  logic       ser_bit, push, accept, pop, empty;
  pkt_entry_t entry, head;

  assign ser_bit = |ser.ser_data;
  // The 64th bit is written straight into the FIFO on its sampling edge.
  assign push    = (state == SHIFT) & ser.ser_valid & (bit_cnt == 6'd63);
  assign entry   = '{data: {shreg, ser_bit}, port: mask | ser.ser_data};
  assign pop     = pkt.pkt_valid & pkt.pkt_ready;

  pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .din    (entry),
    .accept (accept),
    .pop    (pop),
    .dout   (head),
    .empty  (empty),
    .level  (fifo_level)
  );

  assign pkt.pkt_valid = ~empty;
  assign pkt.pkt_data  = head.data;
  assign pkt.pkt_port  = head.port;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      mask     <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      runt_cnt <= '0;
    end else begin
      if (push) begin
        if (accept)              pkt_cnt  <= pkt_cnt + 16'd1;
        else if (drop_cnt != '1) drop_cnt <= drop_cnt + STAT_W'(1);
      end
      case (state)
        IDLE: begin
          if (ser.ser_valid) begin
            shreg   <= (PKT_W-1)'(ser_bit);
            bit_cnt <= 6'd1;
            mask    <= ser.ser_data;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser.ser_valid) begin
            if (bit_cnt == 6'd63) begin
              // Word already pushed; a following strobe restarts in IDLE.
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              shreg   <= {shreg[PKT_W-3:0], ser_bit};
              bit_cnt <= bit_cnt + 6'd1;
              mask    <= mask | ser.ser_data;
            end
          end else begin
            if (runt_cnt != '1) runt_cnt <= runt_cnt + STAT_W'(1);
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
